irq_watchdog: RTL and testbench

- Consumes the sync chain's IRQCLK and VBLANK to produce the 6502 maskable interrupt and the watchdog reset.
- IRQ is latched on every IRQCLK rising edge (vcount 0/64/128/192, four per frame) and held until the CPU acknowledges it.
- The watchdog counts frames (VBLANK rising edges) and pulses a system reset if the CPU stops kicking it.
- Sits between the sync chain and the CPU/reset tree.

---
 rtl/irq_watchdog_if.sv | 26 ++
 rtl/irq_watchdog.sv | 113 +++++++++++
 tb/tb_irq_watchdog.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_watchdog_if.sv
// irq_watchdog_if: sync-chain inputs, CPU strobes and
// interrupt/watchdog outputs of the IRQ/watchdog block.
interface irq_watchdog_if;
  logic       ce5;
  logic       IRQCLK;
  logic       VBLANK;
  logic       irq_ack;
  logic       wdog_clr;
  logic       IRQ_n;
  logic       irq_overrun;
  logic [1:0] irq_phase;
  logic       wdog_reset;
  logic [3:0] wdog_count;

  modport master (
    output ce5, IRQCLK, VBLANK, irq_ack, wdog_clr,
    input  IRQ_n, irq_overrun, irq_phase,
    input  wdog_reset, wdog_count
  );

  modport slave (
    input  ce5, IRQCLK, VBLANK, irq_ack, wdog_clr,
    output IRQ_n, irq_overrun, irq_phase,
    output wdog_reset, wdog_count
  );
endinterface

// File: rtl/irq_watchdog.sv
// irq_watchdog: quarter-frame IRQ latch and frame watchdog,
// fed by the sync chain's IRQCLK and VBLANK.
module irq_watchdog #(
  parameter int WDOG_FRAMES = 8,
  parameter int WDOG_PULSE  = 32,
  parameter bit WDOG_EN     = 1'b1
) (
  input logic           clk,
  input logic           reset,
  irq_watchdog_if.slave bus
);
  typedef enum logic {IDLE, PENDING} irq_st_t;
  typedef enum logic {RUN, FIRE} wd_st_t;

  localparam logic [3:0] CNT_LAST = 4'(WDOG_FRAMES - 1);
  localparam logic [7:0] PULSE_LD = 8'(WDOG_PULSE - 1);

  irq_st_t    irq_q, irq_d;
  wd_st_t     wd_q, wd_d;
  logic       irqclk_d, vblank_d;
  logic       ovr_q, ovr_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] pulse_q, pulse_d;
  logic       rise_irq, rise_vb;

  assign rise_irq = bus.ce5 & bus.IRQCLK & ~irqclk_d;
  assign rise_vb  = bus.ce5 & bus.VBLANK & ~vblank_d;

  // Edge history; reset high so a level already up is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqclk_d <= 1'b1;
      vblank_d <= 1'b1;
    end else if (bus.ce5) begin
      irqclk_d <= bus.IRQCLK;
      vblank_d <= bus.VBLANK;
    end
  end

  // State registers for the IRQ latch and the watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q   <= IDLE;
      ovr_q   <= 1'b0;
      phase_q <= 2'd0;
      wd_q    <= RUN;
      cnt_q   <= 4'd0;
      pulse_q <= 8'd0;
    end else begin
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
      phase_q <= phase_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // IRQ latch: a new edge beats a same-clk ack
  always_comb begin
    irq_d   = irq_q;
    ovr_d   = ovr_q;
    phase_d = phase_q;
    if (rise_irq) begin
      irq_d   = PENDING;
      phase_d = phase_q + 2'd1;
      ovr_d   = (irq_q == PENDING) & ~bus.irq_ack;
    end else if (bus.irq_ack && irq_q == PENDING) begin
      irq_d = IDLE;
      ovr_d = 1'b0;
    end
  end

  // Watchdog: count frames, fire a fixed-length reset pulse
  always_comb begin
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    unique case (wd_q)
      RUN: begin
        if (bus.wdog_clr) begin
          cnt_d = 4'd0;
        end else if (rise_vb) begin
          if (cnt_q == CNT_LAST) begin
            wd_d    = FIRE;
            cnt_d   = 4'd0;
            pulse_d = PULSE_LD;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      FIRE: begin
        cnt_d = 4'd0;
        if (pulse_q == 8'd0) wd_d = RUN;
        else pulse_d = pulse_q - 8'd1;
      end
      default: wd_d = RUN;
    endcase
    if (!WDOG_EN) begin
      wd_d    = RUN;
      cnt_d   = 4'd0;
      pulse_d = 8'd0;
    end
  end

  assign bus.IRQ_n       = (irq_q != PENDING);
  assign bus.irq_overrun = ovr_q;
  assign bus.irq_phase   = phase_q;
  assign bus.wdog_reset  = (wd_q == FIRE);
  assign bus.wdog_count  = cnt_q;
endmodule

// File: tb/tb_irq_watchdog.sv
// tb_irq_watchdog: drives a shortened sync chain and checks
// the IRQ latch and watchdog against a reference model.
module tb_irq_watchdog;
  localparam int HLEN   = 2;
  localparam int FRAMES = 8;
  localparam int PULSE  = 32;
  localparam int FCLK   = 256 * HLEN * 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  irq_watchdog_if bus ();

  irq_watchdog #(
    .WDOG_FRAMES(FRAMES),
    .WDOG_PULSE (PULSE),
    .WDOG_EN    (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cdiv   = 0;
  int pix    = 0;

  // Model: unserviced IRQ count, IRQs taken, frames
  // since kick, reset-pulse clocks still to come.
  int unserv = 0;
  int taken  = 0;
  int frames = 0;
  int left   = 0;
  bit seen_i = 1'b1;
  bit seen_v = 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
    if (errors >= 30) begin
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
    end
  endtask

  function automatic int vcount();
    return (pix / HLEN) % 256;
  endfunction

  function automatic bit irq_lvl();
    return ((vcount() >> 5) & 1) == 0;
  endfunction

  function automatic bit vb_lvl();
    return vcount() < 24;
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [3:0] fr;
    fr = 4'(frames);
    return {unserv == 0, unserv > 1,
            2'(taken % 4), left > 0, fr};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {bus.IRQ_n, bus.irq_overrun,
            bus.irq_phase, bus.wdog_reset,
            bus.wdog_count};
  endfunction

  task automatic step(input bit ack, input bit clr);
    bit ce, ic, vb, ri, rv;
    ce = (cdiv == 0);
    ic = irq_lvl();
    vb = vb_lvl();
    bus.ce5      = ce;
    bus.IRQCLK   = ic;
    bus.VBLANK   = vb;
    bus.irq_ack  = ack;
    bus.wdog_clr = clr;
    @(posedge clk);
    #1;
    ri = ce && ic && !seen_i;
    rv = ce && vb && !seen_v;
    if (ce) begin
      seen_i = ic;
      seen_v = vb;
      pix++;
    end
    cdiv = (cdiv + 1) % 4;
    if (ri) begin
      unserv = ack ? 1 : unserv + 1;
      taken++;
    end else if (ack) begin
      unserv = 0;
    end
    if (left > 0) begin
      left--;
    end else if (clr) begin
      frames = 0;
    end else if (rv) begin
      frames++;
      if (frames == FRAMES) begin
        frames = 0;
        left   = PULSE;
      end
    end
    chk("cycle", obs_vec(), exp_vec());
  endtask

  task automatic do_reset();
    bus.ce5      = 1'b0;
    bus.irq_ack  = 1'b0;
    bus.wdog_clr = 1'b0;
    reset = 1'b1;
    #1;
    unserv = 0;
    taken  = 0;
    frames = 0;
    left   = 0;
    seen_i = 1'b1;
    seen_v = 1'b1;
    chk("rst_state", obs_vec(), exp_vec());
    chk("rst_irq_n", bus.IRQ_n, 1);
    chk("rst_wdog", bus.wdog_reset, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic to_irq_edge(input bit rnd);
    int n;
    n = 0;
    while (!(cdiv == 0 && irq_lvl() && !seen_i)
           && n < 5000) begin
      step(rnd && $urandom_range(0, 40) == 0, 1'b0);
      n++;
    end
    chk("irq_edge_wait", n < 5000, 1);
  endtask

  task automatic to_vb_edge(input bit rnd);
    int n;
    n = 0;
    while (!(cdiv == 0 && vb_lvl() && !seen_v)
           && n < 5000) begin
      step(rnd && $urandom_range(0, 40) == 0, 1'b0);
      n++;
    end
    chk("vb_edge_wait", n < 5000, 1);
  endtask

  initial begin
    int lowrun, irqs, ovmax, hi, n, wait_n;
    bus.ce5      = 1'b0;
    bus.IRQCLK   = 1'b0;
    bus.VBLANK   = 1'b0;
    bus.irq_ack  = 1'b0;
    bus.wdog_clr = 1'b0;
    pix = 250 * HLEN;
    #2;
    do_reset();

    // One frame, no ack
    to_irq_edge(0);
    step(0, 0);
    chk("a_irq_n_v0", bus.IRQ_n, 0);
    chk("a_phase_v0", bus.irq_phase, 1);
    to_irq_edge(0);
    step(0, 0);
    chk("a_ovr_v64", bus.irq_overrun, 1);
    to_irq_edge(0);
    step(0, 0);
    to_irq_edge(0);
    step(0, 0);
    chk("a_phase_v192", bus.irq_phase, 0);
    chk("a_irq_n_v192", bus.IRQ_n, 0);

    // Ack each IRQ 10 clks after it falls
    step(1, 0);
    chk("b_ack_irq_n", bus.IRQ_n, 1);
    chk("b_ack_ovr", bus.irq_overrun, 0);
    lowrun = 0;
    irqs   = 0;
    ovmax  = 0;
    n      = 0;
    while (irqs < 4 && n < FCLK + 1000) begin
      step(lowrun >= 10, 0);
      n++;
      if (bus.irq_overrun) ovmax = 1;
      if (!bus.IRQ_n) begin
        lowrun++;
      end else if (lowrun > 0) begin
        chk("b_low_len", lowrun, 10);
        irqs++;
        lowrun = 0;
      end
    end
    chk("b_irqs", irqs, 4);
    chk("b_ovr", ovmax, 0);

    // Ack coincident with a new edge while pending
    to_irq_edge(0);
    step(0, 0);
    to_irq_edge(0);
    step(1, 0);
    chk("c_irq_n", bus.IRQ_n, 0);
    chk("c_ovr", bus.irq_overrun, 0);
    chk("c_phase", bus.irq_phase, taken % 4);

    // Watchdog, no kicks
    step(0, 1);
    for (int k = 1; k < FRAMES; k++) begin
      to_vb_edge(0);
      step(0, 0);
      chk("d_count", bus.wdog_count, k);
      chk("d_quiet", bus.wdog_reset, 0);
    end
    to_vb_edge(0);
    step(0, 0);
    chk("d_fire", bus.wdog_reset, 1);
    chk("d_fire_cnt", bus.wdog_count, 0);
    hi = 1;
    n  = 0;
    while (n < 200) begin
      step(0, 0);
      n++;
      if (bus.wdog_reset) hi++;
      else break;
    end
    chk("d_pulse_len", hi, PULSE);

    // Kick every frame, one kick on the rise itself
    for (int f = 0; f < 4; f++) begin
      to_vb_edge(1);
      step($urandom_range(0, 1) == 1, f == 2);
      chk("e_count", bus.wdog_count, (f == 2) ? 0 : 1);
      chk("e_quiet", bus.wdog_reset, 0);
      wait_n = $urandom_range(50, 1500);
      for (int i = 0; i < wait_n; i++)
        step($urandom_range(0, 40) == 0, 0);
      step(0, 1);
      chk("e_kick", bus.wdog_count, 0);
    end

    // Reset while firing and pending
    n = 0;
    while (left == 0 && n < FCLK * 9 + 100) begin
      step(0, 0);
      n++;
    end
    chk("f_fire_wait", bus.wdog_reset, 1);
    for (int i = 0; i < 5; i++) step(0, 0);
    chk("f_pend", bus.IRQ_n, 0);
    do_reset();
    to_irq_edge(0);
    chk("f_no_spur", bus.IRQ_n, 1);
    step(0, 0);
    chk("f_edge", bus.IRQ_n, 0);
    chk("f_phase", bus.irq_phase, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
